// File: rtl/xo_issue_scheduler.sv
// In-order issue scheduler for XO-form integer ops: queues decoded instructions and
// issues one per cycle to ALU, multiplier or divider while arbitrating the shared writeback port.
module xo_issue_scheduler #(
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned MUL_LAT      = 3,
  parameter int unsigned DIV_LAT      = 20,
  parameter int unsigned xOpCodeWidth = 9,
  parameter int unsigned regWidth     = 5
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [xOpCodeWidth-1:0] xOpCode_i,
  input  logic [regWidth-1:0]     reg1_i,
  input  logic [regWidth-1:0]     reg2_i,
  input  logic [regWidth-1:0]     reg3_i,
  input  logic                    bit1_i,
  input  logic                    bit2_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    aluEnable_o,
  output logic                    mulEnable_o,
  output logic                    divEnable_o,
  output logic [xOpCodeWidth-1:0] xOpCode_o,
  output logic [regWidth-1:0]     reg1_o,
  output logic [regWidth-1:0]     reg2_o,
  output logic [regWidth-1:0]     reg3_o,
  output logic                    bit1_o,
  output logic                    bit2_o,
  output logic                    illegal_o
);

  localparam int unsigned PTR_W   = (QUEUE_DEPTH > 2) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned RESV_TOP = MAX_LAT + 1;
  localparam int unsigned DCNT_W  = $clog2(DIV_LAT + 1);

  typedef struct packed {
    logic [xOpCodeWidth-1:0] op;
    logic [regWidth-1:0]     r1;
    logic [regWidth-1:0]     r2;
    logic [regWidth-1:0]     r3;
    logic                    b1;
    logic                    b2;
  } entry_t;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_MUL = 2'd1,
    CLS_DIV = 2'd2,
    CLS_ILL = 2'd3
  } cls_t;

  entry_t                q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [RESV_TOP:1]     resv;
  logic [DCNT_W-1:0]     div_cnt;

  logic                  full_c;
  logic                  head_valid_c;
  entry_t                head_c;
  entry_t                in_c;
  cls_t                  head_cls_c;
  logic                  issue_alu_c;
  logic                  issue_mul_c;
  logic                  issue_div_c;
  logic                  issue_ill_c;
  logic                  pop_c;
  logic                  push_c;
  logic [RESV_TOP:1]     resv_nxt_c;

  function automatic cls_t classify(input logic [xOpCodeWidth-1:0] op);
    cls_t c;
    case (int'(op))
      266, 40, 10, 8, 138, 136, 234, 232, 200, 202, 104, 74: c = CLS_ALU;
      235, 75, 11, 233, 73, 9:                               c = CLS_MUL;
      491, 459, 427, 395, 489, 457, 425, 393:                c = CLS_DIV;
      default:                                               c = CLS_ILL;
    endcase
    return c;
  endfunction

  assign full_c       = (count == CNT_W'(QUEUE_DEPTH));
  assign stall_o      = full_c;
  assign head_valid_c = (count != '0);
  assign head_c       = q[head];
  assign head_cls_c   = classify(head_c.op);
  assign in_c         = {xOpCode_i, reg1_i, reg2_i, reg3_i, bit1_i, bit2_i};

  // Head issue decision against writeback reservations and divider occupancy
  assign issue_alu_c = head_valid_c && (head_cls_c == CLS_ALU) && !resv[2];
  assign issue_mul_c = head_valid_c && (head_cls_c == CLS_MUL) && !resv[MUL_LAT+1];
  assign issue_div_c = head_valid_c && (head_cls_c == CLS_DIV) && !resv[DIV_LAT+1]
                       && (div_cnt == '0);
  assign issue_ill_c = head_valid_c && (head_cls_c == CLS_ILL);
  assign pop_c       = issue_alu_c || issue_mul_c || issue_div_c || issue_ill_c;
  assign push_c      = enable_i && !full_c && !flush_i;

  always_comb begin
    resv_nxt_c = {1'b0, resv[RESV_TOP:2]};
    if (issue_alu_c) resv_nxt_c[2] = 1'b1;
    if (issue_mul_c) resv_nxt_c[MUL_LAT+1] = 1'b1;
    if (issue_div_c) resv_nxt_c[DIV_LAT+1] = 1'b1;
  end

  // Queue storage needs no reset; validity is tracked by count
  always_ff @(posedge clock_i) begin
    if (push_c) q[tail] <= in_c;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      resv        <= '0;
      div_cnt     <= '0;
      aluEnable_o <= 1'b0;
      mulEnable_o <= 1'b0;
      divEnable_o <= 1'b0;
      illegal_o   <= 1'b0;
      xOpCode_o   <= '0;
      reg1_o      <= '0;
      reg2_o      <= '0;
      reg3_o      <= '0;
      bit1_o      <= 1'b0;
      bit2_o      <= 1'b0;
    end else begin
      resv        <= resv_nxt_c;
      aluEnable_o <= issue_alu_c;
      mulEnable_o <= issue_mul_c;
      divEnable_o <= issue_div_c;
      illegal_o   <= issue_ill_c;

      if (issue_div_c) begin
        div_cnt <= DCNT_W'(DIV_LAT);
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - DCNT_W'(1);
      end

      if (issue_alu_c || issue_mul_c || issue_div_c) begin
        xOpCode_o <= head_c.op;
        reg1_o    <= head_c.r1;
        reg2_o    <= head_c.r2;
        reg3_o    <= head_c.r3;
        bit1_o    <= head_c.b1;
        bit2_o    <= head_c.b2;
      end

      // Flush empties the queue but lets the head issued this cycle and all reservations stand
      if (flush_i) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (push_c) tail <= tail + PTR_W'(1);
        if (pop_c)  head <= head + PTR_W'(1);
        case ({push_c, pop_c})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
